// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory bus between instruction fetch and the memory stage.
// Optional fetch anti-starvation counter is enabled by defining ARB_STARVE_EN.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fe_req,
  input  logic [31:0] fe_addr,
  output logic        fe_ack,
  output logic [31:0] fe_data,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic        mem_write,
  input  logic [31:0] mem_data_in,
  input  logic        mem_extend,
  input  logic [1:0]  mem_width,
  output logic        mem_ack,
  output logic [31:0] mem_data_out,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_write,
  output logic [31:0] bus_wdata,
  output logic        bus_extend,
  output logic [1:0]  bus_width,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state,
  output logic        dbg_drain_mem
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_FE  = 2'd1,
    ST_GNT_MEM = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  if ((2 ** CNT_W) <= STARVE_LIMIT) begin : g_bad_cnt_w
    $error("mem_arbiter: CNT_W too narrow for STARVE_LIMIT");
  end

  state_t      r_state;
  state_t      w_next_state;
  logic        r_drain_mem;
  logic        w_next_drain_mem;
  logic        w_grant_fe;
  logic        w_grant_mem;
  logic        w_fe_priority;

  logic [31:0] r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic        r_extend;
  logic [1:0]  r_width;

`ifdef ARB_STARVE_EN
  logic [CNT_W-1:0] r_starve_cnt;

  assign w_fe_priority = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts mem grants that made a waiting fetch wait; saturates at the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (w_grant_fe) begin
      r_starve_cnt <= '0;
    end else if (w_grant_mem && fe_req && !w_fe_priority) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_fe_priority = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_drain_mem <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_drain_mem <= w_next_drain_mem;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state     = r_state;
    w_next_drain_mem = r_drain_mem;
    w_grant_fe       = 1'b0;
    w_grant_mem      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_req && !(w_fe_priority && fe_req)) begin
          w_next_state = ST_GNT_MEM;
          w_grant_mem  = 1'b1;
        end else if (fe_req) begin
          w_next_state = ST_GNT_FE;
          w_grant_fe   = 1'b1;
        end
      end
      ST_GNT_FE: begin
        if (bus_ack) begin
          w_next_state = ST_IDLE;
        end else if (!fe_req) begin
          w_next_state     = ST_DRAIN;
          w_next_drain_mem = 1'b0;
        end
      end
      ST_GNT_MEM: begin
        if (bus_ack) begin
          w_next_state = ST_IDLE;
        end else if (!mem_req) begin
          w_next_state     = ST_DRAIN;
          w_next_drain_mem = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (bus_ack) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Bus attributes are captured only at grant so the bus never follows requester inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_extend <= 1'b0;
      r_width  <= 2'd0;
    end else if (w_grant_mem) begin
      r_addr   <= mem_addr;
      r_write  <= mem_write;
      r_wdata  <= mem_data_in;
      r_extend <= mem_extend;
      r_width  <= mem_width;
    end else if (w_grant_fe) begin
      r_addr   <= fe_addr;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_extend <= 1'b0;
      r_width  <= 2'd2;
    end
  end

  // Output logic: completion is bus_ack steered to the current owner; DRAIN swallows it.
  always_comb begin
    bus_req      = (r_state != ST_IDLE);
    fe_ack       = (r_state == ST_GNT_FE) && bus_ack;
    mem_ack      = (r_state == ST_GNT_MEM) && bus_ack;
    fe_data      = fe_ack ? bus_rdata : 32'h0;
    mem_data_out = mem_ack ? bus_rdata : 32'h0;
  end

  assign bus_addr      = r_addr;
  assign bus_write     = r_write;
  assign bus_wdata     = r_wdata;
  assign bus_extend    = r_extend;
  assign bus_width     = r_width;
  assign dbg_state     = r_state;
  assign dbg_drain_mem = r_drain_mem;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants and acks are queued by the stimulus
// and consumed by independent monitors; a small bus model answers after mem_wait cycles.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fe_req = 1'b0;
  logic [31:0] fe_addr = '0;
  logic        fe_ack;
  logic [31:0] fe_data;
  logic        mem_req = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_data_in = '0;
  logic        mem_extend = 1'b0;
  logic [1:0]  mem_width = 2'd0;
  logic        mem_ack;
  logic [31:0] mem_data_out;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic [31:0] bus_wdata;
  logic        bus_extend;
  logic [1:0]  bus_width;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [1:0]  dbg_state;
  logic        dbg_drain_mem;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FE    = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [69:0] grant_q[$];
  int          mem_wait = 0;
  bit          mem_auto = 1'b1;
  logic [31:0] rdata_val = '0;

  mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_ack(fe_ack), .fe_data(fe_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_data_in(mem_data_in), .mem_extend(mem_extend), .mem_width(mem_width),
    .mem_ack(mem_ack), .mem_data_out(mem_data_out),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_extend(bus_extend), .bus_width(bus_width),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .dbg_state(dbg_state), .dbg_drain_mem(dbg_drain_mem)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [69:0] fe_grant(input logic [31:0] a);
    return {S_FE, 1'b0, 2'd2, 1'b0, a, 32'h0};
  endfunction

  function automatic logic [69:0] mem_grant(input logic [31:0] a, input logic w,
                                            input logic [31:0] d, input logic e,
                                            input logic [1:0] wd);
    return {S_MEM, w, wd, e, a, d};
  endfunction

  // Bus model: acks after mem_wait busy cycles, inputs change just after the rising edge
  initial begin
    int wc;
    wc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        wc = 0;
        if (mem_auto) begin
          bus_ack   = 1'b0;
          bus_rdata = '0;
        end
      end else if (mem_auto) begin
        if (bus_ack) begin
          bus_ack   = 1'b0;
          bus_rdata = '0;
        end else if (bus_req) begin
          if (wc >= mem_wait) begin
            bus_ack   = 1'b1;
            bus_rdata = rdata_val;
            wc        = 0;
          end else begin
            wc++;
          end
        end else begin
          wc = 0;
        end
      end
    end
  end

  // Ack monitor
  initial begin
    logic [32:0] exp;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (fe_ack && mem_ack) begin
          checks++;
          errors++;
          $display("FAIL both_acks: fe_ack=1 mem_ack=1, required at most one");
        end else if (fe_ack || mem_ack) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: got mem=%0b fe_data=%h mem_data=%h, required no ack",
                     mem_ack, fe_data, mem_data_out);
          end else begin
            exp = exp_q.pop_front();
            if ({mem_ack, (mem_ack ? mem_data_out : fe_data)} !== exp) begin
              errors++;
              $display("FAIL ack_data: got mem=%0b data=%h, required mem=%0b data=%h",
                       mem_ack, (mem_ack ? mem_data_out : fe_data), exp[32], exp[31:0]);
            end
          end
        end
        checks++;
        if ((!fe_ack && fe_data !== 32'h0) || (!mem_ack && mem_data_out !== 32'h0)) begin
          errors++;
          $display("FAIL idle_data: got fe_data=%h mem_data=%h without ack, required 0",
                   fe_data, mem_data_out);
        end
      end
    end
  end

  // Grant monitor: every rise of bus_req is a new transaction with exact attributes
  initial begin
    logic        prev;
    logic [69:0] exp;
    logic [69:0] got;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_req && !prev) begin
        checks++;
        got = {dbg_state, bus_write, bus_width, bus_extend, bus_addr, bus_wdata};
        if (grant_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: got %h, required none", got);
        end else begin
          exp = grant_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL grant_attr: got %h, required %h", got, exp);
          end
        end
      end
      prev = bus_req;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {23'h0, bus_req, bus_write, bus_extend, bus_width, fe_ack, mem_ack,
                 (bus_addr | bus_wdata | fe_data | mem_data_out)}, 64'h0);
  endtask

  task automatic wait_ack(input bit is_mem, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (is_mem ? mem_ack : fe_ack) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ack in 300 cycles, required one", name);
    end
  endtask

  task automatic fe_txn(input logic [31:0] a);
    fe_addr = a;
    fe_req  = 1'b1;
    wait_ack(1'b0, "fe");
    step();
    fe_req  = 1'b0;
    fe_addr = '0;
  endtask

  // Holds mem_req across acks, renewing attributes, for n transactions
  task automatic mem_seq(input int n, input logic [31:0] base, input logic w,
                         input logic [31:0] d0, input logic e, input logic [1:0] wd);
    for (int k = 0; k < n; k++) begin
      mem_addr    = base + 32'(k * 4);
      mem_write   = w;
      mem_data_in = d0 + 32'(k);
      mem_extend  = e;
      mem_width   = wd;
      mem_req     = 1'b1;
      wait_ack(1'b1, "mem");
      step();
    end
    mem_req = 1'b0;
  endtask

  task automatic report();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no end of test, required completion");
    report();
    $finish;
  end

  // Directed tests
  initial begin
    @(negedge clk);
    @(negedge clk);
    check_zero("reset_outputs");
    check("reset_state", 64'(dbg_state), 64'(S_IDLE));
    step();
    reset_n = 1'b1;
    step();

    // Fetch only, zero-wait memory
    rdata_val = 32'h0000_0013;
    mem_wait  = 0;
    grant_q.push_back(fe_grant(32'h100));
    exp_q.push_back({1'b0, 32'h0000_0013});
    fork
      fe_txn(32'h100);
      begin
        @(negedge clk);
        check("fe_lat_n", 64'(bus_req), 64'd0);
        @(negedge clk);
        check("fe_lat_n1", {62'h0, bus_req, fe_ack}, 64'h3);
      end
    join
    repeat (2) step();

    // Simultaneous requests: mem store wins, fetch follows
    rdata_val = 32'h55AA_1234;
    grant_q.push_back(mem_grant(32'h2000, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'd2));
    grant_q.push_back(fe_grant(32'h140));
    exp_q.push_back({1'b1, 32'h55AA_1234});
    exp_q.push_back({1'b0, 32'h55AA_1234});
    fork
      mem_seq(1, 32'h2000, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'd2);
      fe_txn(32'h140);
    join
    repeat (2) step();

    // Abandoned fetch drains before the mem request is served
    rdata_val = 32'h0000_0077;
    mem_wait  = 3;
    grant_q.push_back(fe_grant(32'h200));
    grant_q.push_back(mem_grant(32'h2400, 1'b0, 32'h0, 1'b1, 2'd0));
    exp_q.push_back({1'b1, 32'h0000_0077});
    fe_addr = 32'h200;
    fe_req  = 1'b1;
    step();
    fe_req  = 1'b0;
    fe_addr = '0;
    fork
      mem_seq(1, 32'h2400, 1'b0, 32'h0, 1'b1, 2'd0);
      begin
        @(negedge clk);
        @(negedge clk);
        check("drain_state", {61'h0, bus_req, dbg_state}, {61'h0, 1'b1, S_DRAIN});
        check("drain_owner", 64'(dbg_drain_mem), 64'd0);
      end
    join
    repeat (2) step();

    // Back-to-back mem stores with exactly one idle cycle between them
    rdata_val = 32'h0000_4242;
    mem_wait  = 1;
    grant_q.push_back(mem_grant(32'h3000, 1'b1, 32'hA0, 1'b0, 2'd1));
    grant_q.push_back(mem_grant(32'h3004, 1'b1, 32'hA1, 1'b0, 2'd1));
    exp_q.push_back({1'b1, 32'h0000_4242});
    exp_q.push_back({1'b1, 32'h0000_4242});
    fork
      mem_seq(2, 32'h3000, 1'b1, 32'hA0, 1'b0, 2'd1);
      begin
        wait_ack(1'b1, "b2b");
        @(negedge clk);
        check("b2b_idle", {61'h0, bus_req, dbg_state}, {61'h0, 1'b0, S_IDLE});
        @(negedge clk);
        check("b2b_restart", 64'(bus_req), 64'd1);
      end
    join
    repeat (2) step();

    // Reset in the middle of a mem transaction
    mem_wait = 20;
    grant_q.push_back(mem_grant(32'h4000, 1'b0, 32'h0, 1'b0, 2'd2));
    mem_addr    = 32'h4000;
    mem_write   = 1'b0;
    mem_data_in = '0;
    mem_extend  = 1'b0;
    mem_width   = 2'd2;
    mem_req     = 1'b1;
    step();
    @(negedge clk);
    check("rst_mid_granted", 64'(dbg_state), 64'(S_MEM));
    step();
    reset_n = 1'b0;
    mem_req = 1'b0;
    #1;
    check_zero("rst_mid_outputs");
    repeat (2) step();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_release_idle", {61'h0, bus_req, dbg_state}, {61'h0, 1'b0, S_IDLE});
    step();
    mem_auto  = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("late_ack_dropped", {31'h0, mem_ack, mem_data_out}, 64'h0);
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    mem_auto  = 1'b1;
    repeat (2) step();

    // Starvation: fetch and mem both held, mem renewed after each ack
    rdata_val = 32'h0000_0099;
    mem_wait  = 0;
`ifdef ARB_STARVE_EN
    for (int k = 0; k < 4; k++) begin
      grant_q.push_back(mem_grant(32'h5000 + 32'(k * 4), 1'b0, 32'(k), 1'b0, 2'd2));
      exp_q.push_back({1'b1, 32'h0000_0099});
    end
    grant_q.push_back(fe_grant(32'h500));
    exp_q.push_back({1'b0, 32'h0000_0099});
    for (int k = 4; k < 6; k++) begin
      grant_q.push_back(mem_grant(32'h5000 + 32'(k * 4), 1'b0, 32'(k), 1'b0, 2'd2));
      exp_q.push_back({1'b1, 32'h0000_0099});
    end
`else
    for (int k = 0; k < 6; k++) begin
      grant_q.push_back(mem_grant(32'h5000 + 32'(k * 4), 1'b0, 32'(k), 1'b0, 2'd2));
      exp_q.push_back({1'b1, 32'h0000_0099});
    end
    grant_q.push_back(fe_grant(32'h500));
    exp_q.push_back({1'b0, 32'h0000_0099});
`endif
    fork
      mem_seq(6, 32'h5000, 1'b0, 32'h0, 1'b0, 2'd2);
      fe_txn(32'h500);
    join

    for (int i = 0; i < 50 && (exp_q.size() != 0 || grant_q.size() != 0); i++) step();
    repeat (3) step();
    check("queues_drained", {32'(exp_q.size()), 32'(grant_q.size())}, 64'h0);
    report();
    $finish;
  end

endmodule
